// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the asynchronous FIFO pointer controllers.
// Contents:
//   MAX_PTR_W  - widest pointer the helpers handle
//   depth_of   - number of RAM words for a given address width
//   bin2gray   - binary to reflected Gray code
//   gray2bin   - reflected Gray code to binary (MSB-down XOR prefix)
// The conversion functions take zero-extended operands. The Gray mapping of a
// zero-extended value equals the zero-extended Gray value, so one function
// serves every pointer width up to MAX_PTR_W.
package fifo_ptr_pkg;

  localparam int MAX_PTR_W = 32;

  function automatic int depth_of(input int addr_size);
    return 1 << addr_size;
  endfunction

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter.
// Ports:
//   gray [WIDTH-1:0]  Gray-coded input
//   bin  [WIDTH-1:0]  binary equivalent; each bit is the XOR of all Gray bits
//                     at and above its position
module gray2bin_conv #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/wrt_ptr_ctrl_level.sv
// Write-side pointer controller for the asynchronous FIFO (write clock domain).
// Keeps the binary/Gray write pointers, drives the RAM write port, and
// produces registered full, fill level, almost-full and sticky overflow.
// Ports:
//   wrt_clk, wrt_rst     clock, synchronous active-high reset
//   wrt_inc              write request
//   sync_rd_ptr          Gray read pointer already synchronised into wrt_clk
//   af_thresh            almost-full threshold in words (quasi-static)
//   ovf_clr              clears the sticky overflow flag
//   wrt_accept           RAM write enable (combinational)
//   wrt_addr             RAM write address
//   wrt_ptr              registered Gray write pointer, to the synchroniser
//   wrt_full             registered full
//   wrt_almost_full      registered level >= af_thresh
//   wrt_level            registered occupancy, 0..DEPTH
//   wrt_ovf              sticky overflow
// Handshake: wrt_inc is the request (valid) and ~wrt_full the ready; a write
// transfers exactly on cycles where wrt_accept = wrt_inc & ~wrt_full is high,
// and a request while full is dropped and flagged in wrt_ovf.
module wrt_ptr_ctrl_level
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_SIZE = 4
) (
  input  logic                 wrt_clk,
  input  logic                 wrt_rst,
  input  logic                 wrt_inc,
  input  logic [ADDR_SIZE:0]   sync_rd_ptr,
  input  logic [ADDR_SIZE:0]   af_thresh,
  input  logic                 ovf_clr,
  output logic                 wrt_accept,
  output logic [ADDR_SIZE-1:0] wrt_addr,
  output logic [ADDR_SIZE:0]   wrt_ptr,
  output logic                 wrt_full,
  output logic                 wrt_almost_full,
  output logic [ADDR_SIZE:0]   wrt_level,
  output logic                 wrt_ovf
);

  localparam int PW = ADDR_SIZE + 1;

  logic [PW-1:0] wrt_bin;
  logic [PW-1:0] bin_nxt;
  logic [PW-1:0] gray_nxt;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_full_cmp;
  logic [PW-1:0] level_nxt;
  logic          full_nxt;
  logic          af_nxt;

  assign wrt_accept = wrt_inc & ~wrt_full;
  assign wrt_addr   = wrt_bin[ADDR_SIZE-1:0];

  assign bin_nxt  = wrt_bin + PW'(wrt_accept);
  assign gray_nxt = bin_nxt ^ (bin_nxt >> 1);

  // Full when the write pointer is exactly one lap ahead of the read pointer:
  // in Gray code that is the read pointer with its top two bits inverted.
  assign rd_full_cmp = {~sync_rd_ptr[ADDR_SIZE:ADDR_SIZE-1], sync_rd_ptr[ADDR_SIZE-2:0]};
  assign full_nxt    = (gray_nxt == rd_full_cmp);

  gray2bin_conv #(
    .WIDTH(PW)
  ) u_rd_g2b (
    .gray(sync_rd_ptr),
    .bin (rd_bin)
  );

  // Modular difference is exact because the pointers are never more than
  // DEPTH apart; it lags real occupancy by the synchroniser latency.
  assign level_nxt = bin_nxt - rd_bin;
  assign af_nxt    = (level_nxt >= af_thresh);

  always_ff @(posedge wrt_clk) begin
    if (wrt_rst) begin
      wrt_bin         <= '0;
      wrt_ptr         <= '0;
      wrt_full        <= 1'b0;
      wrt_almost_full <= 1'b0;
      wrt_level       <= '0;
      wrt_ovf         <= 1'b0;
    end else begin
      wrt_bin         <= bin_nxt;
      wrt_ptr         <= gray_nxt;
      wrt_full        <= full_nxt;
      wrt_almost_full <= af_nxt;
      wrt_level       <= level_nxt;
      // A dropped write sets the flag even if a clear arrives with it.
      if (wrt_inc && wrt_full) begin
        wrt_ovf <= 1'b1;
      end else if (ovf_clr) begin
        wrt_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wrt_ptr_ctrl_level.sv
module tb_wrt_ptr_ctrl_level;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic          wrt_clk = 1'b0;
  logic          wrt_rst = 1'b1;
  logic          wrt_inc = 1'b0;
  logic [PW-1:0] sync_rd_ptr = '0;
  logic [PW-1:0] af_thresh = PW'(12);
  logic          ovf_clr = 1'b0;
  logic          wrt_accept;
  logic [AW-1:0] wrt_addr;
  logic [PW-1:0] wrt_ptr;
  logic          wrt_full;
  logic          wrt_almost_full;
  logic [PW-1:0] wrt_level;
  logic          wrt_ovf;

  always #5 wrt_clk = ~wrt_clk;

  wrt_ptr_ctrl_level #(.ADDR_SIZE(AW)) dut (
    .wrt_clk        (wrt_clk),
    .wrt_rst        (wrt_rst),
    .wrt_inc        (wrt_inc),
    .sync_rd_ptr    (sync_rd_ptr),
    .af_thresh      (af_thresh),
    .ovf_clr        (ovf_clr),
    .wrt_accept     (wrt_accept),
    .wrt_addr       (wrt_addr),
    .wrt_ptr        (wrt_ptr),
    .wrt_full       (wrt_full),
    .wrt_almost_full(wrt_almost_full),
    .wrt_level      (wrt_level),
    .wrt_ovf        (wrt_ovf)
  );

  // ---------------- reference model (counts of words) ----------------
  int   errors = 0;
  int   checks = 0;
  int   m_wr   = 0;   // total writes accepted since reset
  int   rd_cnt = 0;   // total reads the read side has published
  int   m_level = 0;
  bit   m_full = 0, m_af = 0, m_ovf = 0;
  logic [31:0] exp_q[$];

  function automatic logic [PW-1:0] to_gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    exp_q.push_back(32'(to_gray(m_wr)));
    exp_q.push_back(32'(m_wr % DEPTH));
    exp_q.push_back(32'(m_level));
    exp_q.push_back(32'(m_full));
    exp_q.push_back(32'(m_af));
    exp_q.push_back(32'(m_ovf));
    chk({tag, ".ptr"},   32'(wrt_ptr),         exp_q.pop_front());
    chk({tag, ".addr"},  32'(wrt_addr),        exp_q.pop_front());
    chk({tag, ".level"}, 32'(wrt_level),       exp_q.pop_front());
    chk({tag, ".full"},  32'(wrt_full),        exp_q.pop_front());
    chk({tag, ".af"},    32'(wrt_almost_full), exp_q.pop_front());
    chk({tag, ".ovf"},   32'(wrt_ovf),         exp_q.pop_front());
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, check the combinational write enable,
  // advance the model on the edge, then compare every registered output.
  task automatic step(input bit rst, input bit inc, input bit clr, input string tag);
    bit acc;
    @(negedge wrt_clk);
    wrt_rst     = rst;
    wrt_inc     = inc;
    ovf_clr     = clr;
    sync_rd_ptr = to_gray(rd_cnt);
    #1;
    acc = inc && !m_full;
    if (!rst) chk({tag, ".accept"}, 32'(wrt_accept), 32'(acc));
    @(posedge wrt_clk);
    if (rst) begin
      m_wr = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      if (inc && m_full) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (acc) m_wr++;
      m_level = m_wr - rd_cnt;
      m_full  = (m_level == DEPTH);
      m_af    = (m_level >= int'(af_thresh));
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rd_cnt = 0;
    step(1, 1, 0, "reset");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  logic [PW-1:0] prev_ptr;
  bit            saw_wrap;

  initial begin
    // Reset held for two edges with a write request pending.
    rd_cnt = 0;
    step(1, 1, 0, "reset0");
    step(1, 1, 0, "reset1");
    chk("reset.ptr_zero", 32'(wrt_ptr), 0);

    // Fill from empty.
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, $sformatf("fill%0d", i));
      if (i == 12) begin
        chk("fill12.level", 32'(wrt_level), 12);
        chk("fill12.af", 32'(wrt_almost_full), 1);
      end
    end
    chk("fill16.ptr", 32'(wrt_ptr), 32'b11000);
    chk("fill16.full", 32'(wrt_full), 1);

    // Overflow behaviour.
    step(0, 1, 0, "ovf_set");
    chk("ovf_set.ptr_held", 32'(wrt_ptr), 32'b11000);
    chk("ovf_set.flag", 32'(wrt_ovf), 1);
    step(0, 0, 1, "ovf_clr");
    chk("ovf_clr.flag", 32'(wrt_ovf), 0);
    step(0, 1, 1, "ovf_set_wins");
    chk("ovf_set_wins.flag", 32'(wrt_ovf), 1);
    step(0, 0, 1, "ovf_clr2");

    // Drain while full, refill, then write with simultaneous read.
    rd_cnt = 4;
    step(0, 0, 0, "drain");
    chk("drain.level", 32'(wrt_level), 12);
    for (int i = 0; i < 4; i++) step(0, 1, 0, "refill");
    chk("refill.full", 32'(wrt_full), 1);
    rd_cnt = 5;
    step(0, 0, 0, "rd_one");
    rd_cnt = 6;
    step(0, 1, 0, "wr_and_rd");
    chk("wr_and_rd.level", 32'(wrt_level), 15);

    // Wrap: read side trails three words behind.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, "wrap_pre");
    saw_wrap = 0;
    for (int i = 0; i < 40; i++) begin
      prev_ptr = wrt_ptr;
      rd_cnt = m_wr - 2;
      step(0, 1, 0, "wrap");
      chk("wrap.level3", 32'(wrt_level), 3);
      chk("wrap.one_bit", 32'($countones(prev_ptr ^ wrt_ptr)), 1);
      if (prev_ptr == 5'b10000 && wrt_ptr == 5'b00000) saw_wrap = 1;
    end
    chk("wrap.seen", 32'(saw_wrap), 1);

    // Reset mid-operation.
    do_reset();
    for (int i = 0; i < 7; i++) step(0, 1, 0, "mid_fill");
    chk("mid_fill.level", 32'(wrt_level), 7);
    rd_cnt = 0;
    step(1, 1, 0, "mid_reset");
    step(0, 1, 0, "post_reset");
    chk("post_reset.ptr", 32'(wrt_ptr), 1);

    // Threshold 0 asserts on the first edge after reset release.
    af_thresh = '0;
    do_reset();
    step(0, 0, 0, "af_zero");
    chk("af_zero.af", 32'(wrt_almost_full), 1);

    // Randomised traffic at several thresholds (20 can never be reached).
    for (int t = 0; t < 3; t++) begin
      af_thresh = (t == 0) ? PW'(12) : (t == 1) ? PW'(20) : PW'($urandom_range(0, 16));
      do_reset();
      for (int i = 0; i < 300; i++) begin
        if (rd_cnt < m_wr && $urandom_range(0, 2) != 0) rd_cnt++;
        step(0, 1'($urandom_range(0, 1) | (t == 2 ? 1 : 0)),
             1'($urandom_range(0, 7) == 0), "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
